// File: rtl/ram_pair_master.sv
// rtl/ram_pair_master.sv - paired read/write initiator for the async dual-address RAM model
// Optional statistics counters: define RAM_PAIR_MASTER_STATS_EN.
module ram_pair_master #(
  parameter int AddressSize   = 4,
  parameter int WordSize      = 4,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [AddressSize-1:0] req_addr1,
  input  logic [AddressSize-1:0] req_addr2,
  input  logic [WordSize-1:0]    req_wdata1,
  input  logic [WordSize-1:0]    req_wdata2,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WordSize-1:0]    rsp_rdata1,
  output logic [WordSize-1:0]    rsp_rdata2,
  output logic [AddressSize-1:0] ram_addr1,
  output logic [AddressSize-1:0] ram_addr2,
  inout  wire  [WordSize-1:0]    ram_data1,
  inout  wire  [WordSize-1:0]    ram_data2,
  output logic                   ram_re,
  output logic                   ram_we,
  output logic                   busy
`ifdef RAM_PAIR_MASTER_STATS_EN
  ,
  output logic [15:0]            stat_reads,
  output logic [15:0]            stat_writes
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  logic [2:0]             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   write_q;
  logic [AddressSize-1:0] addr1_q, addr2_q;
  logic [WordSize-1:0]    wdata1_q, wdata2_q;
  logic [WordSize-1:0]    rdata1_q, rdata2_q;
  logic                   accept;
  logic                   strobe_done;
  logic                   drive_en;

  assign req_ready   = (state_q == IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign strobe_done = (state_q == STROBE) && (cnt_q == STROBE_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        cnt_d   = 4'd0;
        state_d = STROBE;
      end
      STROBE: begin
        if (strobe_done) begin
          cnt_d   = 4'd0;
          state_d = write_q ? HOLD : RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= req_write;
        addr1_q  <= req_addr1;
        addr2_q  <= req_addr2;
        wdata1_q <= req_wdata1;
        wdata2_q <= req_wdata2;
      end
      // Read data is sampled while RE is still asserted, on the final strobe edge.
      if (strobe_done && !write_q) begin
        rdata1_q <= ram_data1;
        rdata2_q <= ram_data2;
      end
    end
  end

`ifdef RAM_PAIR_MASTER_STATS_EN
  logic [15:0] stat_reads_q, stat_writes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_q  <= 16'd0;
      stat_writes_q <= 16'd0;
    end else if (accept) begin
      if (req_write) stat_writes_q <= stat_writes_q + 16'd1;
      else           stat_reads_q  <= stat_reads_q + 16'd1;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif

  // Buses are driven only during write phases, so RE and bus drive never overlap.
  assign drive_en  = write_q && ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD));
  assign ram_data1 = drive_en ? wdata1_q : 'z;
  assign ram_data2 = drive_en ? wdata2_q : 'z;

  assign ram_re     = !write_q && ((state_q == SETUP) || (state_q == STROBE));
  assign ram_we     = write_q && (state_q == STROBE);
  assign ram_addr1  = addr1_q;
  assign ram_addr2  = addr2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata1 = rdata1_q;
  assign rsp_rdata2 = rdata2_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ram_pair_master.sv
// tb/tb_ram_pair_master.sv - directed bench for ram_pair_master with a behavioural dual-address RAM
module tb_ram_pair_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_write, rsp_ready;
  logic [3:0] req_addr1, req_addr2, req_wdata1, req_wdata2;
  logic       req_ready, rsp_valid, ram_re, ram_we, busy;
  logic [3:0] rsp_rdata1, rsp_rdata2, ram_addr1, ram_addr2;
  wire  [3:0] ram_data1, ram_data2;
`ifdef RAM_PAIR_MASTER_STATS_EN
  logic [15:0] stat_reads, stat_writes;
`endif

  logic       rst4, req_valid4;
  logic       req_ready4, rsp_valid4, ram_re4, ram_we4, busy4;
  logic [3:0] rsp_rdata14, rsp_rdata24, ram_addr14, ram_addr24;
  wire  [3:0] ram_data14, ram_data24;
  logic       tb_drv4;
`ifdef RAM_PAIR_MASTER_STATS_EN
  logic [15:0] stat_reads4, stat_writes4;
`endif

  logic [3:0] mem [16];
  int         n_pass = 0;
  int         n_total = 0;
  logic [3:0] held1, held2;
  int         guard;

  always #5 clk = ~clk;

  ram_pair_master #(.AddressSize(4), .WordSize(4), .STROBE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata1(req_wdata1), .req_wdata2(req_wdata2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
    .ram_addr1(ram_addr1), .ram_addr2(ram_addr2), .ram_data1(ram_data1), .ram_data2(ram_data2),
    .ram_re(ram_re), .ram_we(ram_we), .busy(busy)
`ifdef RAM_PAIR_MASTER_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
  );

  ram_pair_master #(.AddressSize(4), .WordSize(4), .STROBE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4), .req_write(1'b1),
    .req_addr1(4'd3), .req_addr2(4'd9), .req_wdata1(4'hA), .req_wdata2(4'h5),
    .rsp_valid(rsp_valid4), .rsp_ready(1'b1), .rsp_rdata1(rsp_rdata14), .rsp_rdata2(rsp_rdata24),
    .ram_addr1(ram_addr14), .ram_addr2(ram_addr24), .ram_data1(ram_data14), .ram_data2(ram_data24),
    .ram_re(ram_re4), .ram_we(ram_we4), .busy(busy4)
`ifdef RAM_PAIR_MASTER_STATS_EN
    , .stat_reads(stat_reads4), .stat_writes(stat_writes4)
`endif
  );

  // RAM model: drives data while RE is high; port-2 write lands last on the same address.
  assign ram_data1 = ram_re ? mem[ram_addr1] : 'z;
  assign ram_data2 = ram_re ? mem[ram_addr2] : 'z;
  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr1] <= ram_data1;
      mem[ram_addr2] <= ram_data2;
    end
  end

  assign ram_data14 = tb_drv4 ? 4'h5 : 'z;
  assign ram_data24 = tb_drv4 ? 4'hC : 'z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [3:0] a1, a2, d1, d2);
    req_valid = 1'b1; req_write = wr;
    req_addr1 = a1; req_addr2 = a2; req_wdata1 = d1; req_wdata2 = d2;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [3:0] a1, a2, d1, d2);
    issue(1'b1, a1, a2, d1, d2);
    check({tag, "_setup_we"}, 32'(ram_we), 32'd0);
    check({tag, "_setup_d1"}, 32'(ram_data1), 32'(d1));
    tick();
    check({tag, "_strobe_we"}, 32'(ram_we), 32'd1);
    check({tag, "_strobe_re"}, 32'(ram_re), 32'd0);
    check({tag, "_strobe_bus"}, {24'd0, ram_data1, ram_data2}, {24'd0, d1, d2});
    tick();
    check({tag, "_hold_we"}, 32'(ram_we), 32'd0);
    check({tag, "_hold_addr"}, {24'd0, ram_addr1, ram_addr2}, {24'd0, a1, a2});
    check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [3:0] a1, a2, e1, e2);
    rsp_ready = 1'b1;
    issue(1'b0, a1, a2, 4'h0, 4'h0);
    check({tag, "_setup_re"}, 32'(ram_re), 32'd1);
    check({tag, "_setup_we"}, 32'(ram_we), 32'd0);
    tick();
    check({tag, "_strobe_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_data"}, {24'd0, rsp_rdata1, rsp_rdata2}, {24'd0, e1, e2});
    check({tag, "_rsp_re"}, 32'(ram_re), 32'd0);
    tick();
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1; tb_drv4 = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0; req_valid4 = 1'b0;
    req_addr1 = '0; req_addr2 = '0; req_wdata1 = '0; req_wdata2 = '0;
    tick(); tick();
    check("rst_ready_low", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_re_we", {30'd0, ram_re, ram_we}, 32'd0);
    check("rst_addr", {24'd0, ram_addr1, ram_addr2}, 32'd0);
    check("rst_rsp", {23'd0, rsp_valid, rsp_rdata1, rsp_rdata2}, 32'd0);
    rst = 1'b0; rst4 = 1'b0;
    tick();
    check("idle_ready", 32'(req_ready), 32'd1);

    do_write("wr39", 4'd3, 4'd9, 4'hA, 4'h5);
    check("mem3", 32'(mem[3]), 32'hA);
    check("mem9", 32'(mem[9]), 32'h5);
    do_read("rd39", 4'd3, 4'd9, 4'hA, 4'h5);

    // Back-pressure: response must hold while a competing request is presented.
    rsp_ready = 1'b0;
    issue(1'b0, 4'd9, 4'd3, 4'h0, 4'h0);
    guard = 0;
    while (!rsp_valid && guard < 20) begin tick(); guard++; end
    check("bp_valid_seen", 32'(rsp_valid), 32'd1);
    held1 = rsp_rdata1; held2 = rsp_rdata2;
    check("bp_data", {24'd0, held1, held2}, {24'd0, 4'h5, 4'hA});
    req_valid = 1'b1; req_write = 1'b1; req_addr1 = 4'd0; req_addr2 = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", {24'd0, rsp_rdata1, rsp_rdata2}, {24'd0, held1, held2});
      check("bp_no_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    check("bp_no_capture", 32'(ram_we), 32'd0);

    do_write("wr77", 4'd7, 4'd7, 4'h1, 4'h2);
    check("mem7", 32'(mem[7]), 32'h2);
    do_read("rd77", 4'd7, 4'd7, 4'h2, 4'h2);

`ifdef RAM_PAIR_MASTER_STATS_EN
    check("stat_writes", 32'(stat_writes), 32'd2);
    check("stat_reads", 32'(stat_reads), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("stat_clr", {stat_reads, stat_writes}, 32'd0);
`endif

    // Reset during the second strobe cycle of a long write.
    req_valid4 = 1'b1;
    tick();
    req_valid4 = 1'b0;
    check("r4_setup_bus", 32'(ram_data14), 32'hA);
    tick();
    check("r4_strobe1_we", 32'(ram_we4), 32'd1);
    tick();
    check("r4_strobe2_we", 32'(ram_we4), 32'd1);
    rst4 = 1'b1;
    tick();
    check("r4_we_drop", 32'(ram_we4), 32'd0);
    check("r4_busy", 32'(busy4), 32'd0);
    check("r4_rsp_valid", 32'(rsp_valid4), 32'd0);
    check("r4_ready_in_rst", 32'(req_ready4), 32'd0);
    check("r4_addr", {24'd0, ram_addr14, ram_addr24}, 32'd0);
    rst4 = 1'b0;
    tb_drv4 = 1'b1;
    tick();
    check("r4_ready_after", 32'(req_ready4), 32'd1);
    check("r4_bus_released", {24'd0, ram_data14, ram_data24}, 32'h5C);
    check("r4_re", 32'(ram_re4), 32'd0);
    check("r4_rdata", {24'd0, rsp_rdata14, rsp_rdata24}, 32'd0);
    tb_drv4 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
